// File: rtl/pred_pkg.sv
// Shared constants for the predicate register file and its scoreboard.
package pred_pkg;

  localparam int NUM_PRED    = 8;   // predicate registers p0..p7
  localparam int PIDX_W      = 3;   // predicate index width
  localparam int P_TRUE      = 0;   // hard-wired always-true predicate index
  localparam int STALL_CNT_W = 16;  // width of the saturating stall counter

endpackage

// File: rtl/pred_scoreboard.sv
// Busy-bit tracking for the predicate file: one outstanding write per
// predicate. A writeback clears its bit, an accepted predicate-writing issue
// sets it (set wins over a same-edge clear), and flush clears everything.
// p0 is never busy.
module pred_scoreboard #(
  parameter int NUM_PRED = 8,
  parameter int PIDX_W   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_valid,
  input  logic [PIDX_W-1:0]   set_idx,
  input  logic                clr_valid,
  input  logic [PIDX_W-1:0]   clr_idx,
  input  logic                flush,
  input  logic [PIDX_W-1:0]   guard_idx,
  input  logic                dst_valid,
  input  logic [PIDX_W-1:0]   dst_idx,
  output logic                guard_busy,
  output logic                dst_busy,
  output logic [NUM_PRED-1:0] busy
);

  import pred_pkg::*;

  localparam logic [PIDX_W-1:0] ZERO_IDX = PIDX_W'(P_TRUE);

  logic [NUM_PRED-1:0] busy_r;
  logic [NUM_PRED-1:0] busy_nxt_s;
  logic                clr_hit_s;
  logic                set_hit_s;

  // Hazard detection; a same-cycle writeback to the index hides its busy bit.
  always_comb begin
    guard_busy = busy_r[guard_idx] &&
                 !(clr_valid && (clr_idx == guard_idx) && (guard_idx != ZERO_IDX));
    dst_busy   = dst_valid && (dst_idx != ZERO_IDX) && busy_r[dst_idx] &&
                 !(clr_valid && (clr_idx == dst_idx));
  end

  // Next busy vector: set beats clear, flush beats everything, p0 stays clear.
  always_comb begin
    busy_nxt_s = {NUM_PRED{1'b0}};
    clr_hit_s  = 1'b0;
    set_hit_s  = 1'b0;
    for (int i = 0; i < NUM_PRED; i++) begin
      clr_hit_s     = clr_valid && (clr_idx == PIDX_W'(i));
      set_hit_s     = set_valid && (set_idx == PIDX_W'(i));
      busy_nxt_s[i] = (i != P_TRUE) && !flush &&
                      (set_hit_s || (busy_r[i] && !clr_hit_s));
    end
  end

  // Busy-bit register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r <= {NUM_PRED{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign busy = busy_r;

endmodule

// File: rtl/pred_regfile.sv
// Predicate register file with guard evaluation, writeback bypass to the
// guard read, issue hazard checks via pred_scoreboard, a sticky error flag
// for writebacks to idle registers and a saturating stall counter.
module pred_regfile #(
  parameter int NUM_PRED = pred_pkg::NUM_PRED,
  parameter int PIDX_W   = pred_pkg::PIDX_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  input  logic [PIDX_W-1:0]      issue_guard_idx,
  input  logic                   issue_guard_neg,
  input  logic                   issue_dst_valid,
  input  logic [PIDX_W-1:0]      issue_dst_idx,
  output logic                   issue_stall,
  output logic                   issue_exec,
  input  logic                   wb_valid,
  input  logic [PIDX_W-1:0]      wb_idx,
  input  logic                   wb_data,
  input  logic                   flush,
  input  logic [PIDX_W-1:0]      rd_idx,
  output logic                   rd_data,
  output logic                   wb_err,
  output logic [pred_pkg::STALL_CNT_W-1:0] stall_cnt
);

  import pred_pkg::*;

  localparam logic [PIDX_W-1:0] ZERO_IDX = PIDX_W'(P_TRUE);

  logic [NUM_PRED-1:0]    vals_r;
  logic                   wb_err_r;
  logic [STALL_CNT_W-1:0] stall_cnt_r;

  logic                   wb_wr_s;
  logic                   bypass_s;
  logic                   guard_val_s;
  logic                   guard_busy_s;
  logic                   dst_busy_s;
  logic                   set_s;
  logic [NUM_PRED-1:0]    busy_s;

  // Stored predicate read; p0 is the constant-true predicate.
  function automatic logic pred_read(input logic [NUM_PRED-1:0] vals,
                                     input logic [PIDX_W-1:0]   idx);
    return (idx == ZERO_IDX) ? 1'b1 : vals[idx];
  endfunction

  pred_scoreboard #(
    .NUM_PRED (NUM_PRED),
    .PIDX_W   (PIDX_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_valid  (set_s),
    .set_idx    (issue_dst_idx),
    .clr_valid  (wb_valid),
    .clr_idx    (wb_idx),
    .flush      (flush),
    .guard_idx  (issue_guard_idx),
    .dst_valid  (issue_dst_valid),
    .dst_idx    (issue_dst_idx),
    .guard_busy (guard_busy_s),
    .dst_busy   (dst_busy_s),
    .busy       (busy_s)
  );

  // Guard evaluation with writeback bypass and issue accept decision.
  always_comb begin
    wb_wr_s     = wb_valid && (wb_idx != ZERO_IDX);
    bypass_s    = wb_valid && (wb_idx == issue_guard_idx) && (issue_guard_idx != ZERO_IDX);
    guard_val_s = bypass_s ? wb_data : pred_read(vals_r, issue_guard_idx);
    issue_stall = issue_valid && (guard_busy_s || dst_busy_s);
    issue_exec  = issue_valid && !issue_stall && (guard_val_s ^ issue_guard_neg);
    set_s       = issue_exec && issue_dst_valid && (issue_dst_idx != ZERO_IDX);
    rd_data     = pred_read(vals_r, rd_idx);
  end

  // Predicate value array; writebacks land even under flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vals_r <= {NUM_PRED{1'b0}};
    end else if (wb_wr_s) begin
      vals_r[wb_idx] <= wb_data;
    end else begin
      vals_r <= vals_r;
    end
  end

  // Sticky flag for a writeback arriving at a register with no pending write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_err_r <= 1'b0;
    end else if (wb_wr_s && !busy_s[wb_idx]) begin
      wb_err_r <= 1'b1;
    end else begin
      wb_err_r <= wb_err_r;
    end
  end

  // Saturating count of cycles in which issue was held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_r <= {STALL_CNT_W{1'b0}};
    end else if (issue_stall && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign wb_err    = wb_err_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pred_regfile.sv
// Bench for pred_regfile: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the predicate file.
module tb_pred_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [2:0]  issue_guard_idx;
  logic        issue_guard_neg;
  logic        issue_dst_valid;
  logic [2:0]  issue_dst_idx;
  logic        issue_stall;
  logic        issue_exec;
  logic        wb_valid;
  logic [2:0]  wb_idx;
  logic        wb_data;
  logic        flush;
  logic [2:0]  rd_idx;
  logic        rd_data;
  logic        wb_err;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  pred_regfile dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .issue_valid     (issue_valid),
    .issue_guard_idx (issue_guard_idx),
    .issue_guard_neg (issue_guard_neg),
    .issue_dst_valid (issue_dst_valid),
    .issue_dst_idx   (issue_dst_idx),
    .issue_stall     (issue_stall),
    .issue_exec      (issue_exec),
    .wb_valid        (wb_valid),
    .wb_idx          (wb_idx),
    .wb_data         (wb_data),
    .flush           (flush),
    .rd_idx          (rd_idx),
    .rd_data         (rd_data),
    .wb_err          (wb_err),
    .stall_cnt       (stall_cnt)
  );

  // Behavioural model state
  bit          m_val  [8];
  bit          m_busy [8];
  bit          m_err;
  int unsigned m_cnt;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_val[i]  = 1'b0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  task automatic idle();
    rst_n           = 1'b1;
    issue_valid     = 1'b0;
    issue_guard_idx = 3'd0;
    issue_guard_neg = 1'b0;
    issue_dst_valid = 1'b0;
    issue_dst_idx   = 3'd0;
    wb_valid        = 1'b0;
    wb_idx          = 3'd0;
    wb_data         = 1'b0;
    flush           = 1'b0;
  endtask

  task automatic issue(input int g, input bit neg, input bit dv, input int d);
    issue_valid     = 1'b1;
    issue_guard_idx = 3'(g);
    issue_guard_neg = neg;
    issue_dst_valid = dv;
    issue_dst_idx   = 3'(d);
  endtask

  task automatic wb(input int idx, input bit data);
    wb_valid = 1'b1;
    wb_idx   = 3'(idx);
    wb_data  = data;
  endtask

  // One cycle: predict combinational outputs, compare on the falling edge,
  // then apply the architectural update rules at the rising edge.
  task automatic tick(input bit do_chk);
    bit g_val, g_busy, d_busy, st, ex;
    int gi, di, wi;
    @(negedge clk);
    gi = int'(issue_guard_idx);
    di = int'(issue_dst_idx);
    wi = int'(wb_idx);
    if (wb_valid && wi == gi && gi != 0) g_val = wb_data;
    else if (gi == 0)                    g_val = 1'b1;
    else                                 g_val = m_val[gi];
    g_busy = (gi != 0) && m_busy[gi] && !(wb_valid && wi == gi);
    d_busy = issue_dst_valid && (di != 0) && m_busy[di] && !(wb_valid && wi == di);
    st = issue_valid && (g_busy || d_busy);
    ex = issue_valid && !st && (g_val != issue_guard_neg);
    if (do_chk) begin
      check("issue_stall", 16'(issue_stall), 16'(st));
      check("issue_exec",  16'(issue_exec),  16'(ex));
      check("rd_data",     16'(rd_data),     16'((rd_idx == 3'd0) ? 1'b1 : m_val[int'(rd_idx)]));
      check("wb_err",      16'(wb_err),      16'(m_err));
      check("stall_cnt",   stall_cnt,        16'(m_cnt));
    end
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (wb_valid && wi != 0) begin
        if (!m_busy[wi]) m_err = 1'b1;
        m_val[wi]  = wb_data;
        m_busy[wi] = 1'b0;
      end
      if (ex && issue_dst_valid && di != 0) m_busy[di] = 1'b1;
      if (flush) for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
      if (st && m_cnt < 65535) m_cnt++;
    end
    #1;
  endtask

  initial begin
    idle();
    rd_idx = 3'd0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    idle();

    // Reset state and p0 guard; p3 reads 0
    rd_idx = 3'd3;
    issue(0, 1'b0, 1'b0, 0);
    tick(1'b1);
    check("p0_exec", 16'(issue_exec), 16'd1);

    // Write p2, then stall on guard p2, then writeback bypass releases it
    idle(); issue(0, 1'b0, 1'b1, 2); tick(1'b1);
    idle(); issue(2, 1'b0, 1'b0, 0); tick(1'b1);
    check("stall_cnt_one", stall_cnt, 16'd1);
    idle(); issue(2, 1'b0, 1'b0, 0); wb(2, 1'b1);
    #1; check("bypass_exec", 16'(issue_exec), 16'd1);
    tick(1'b1);
    idle(); rd_idx = 3'd2; tick(1'b1);

    // Negated guard on p1 (=0) sets busy[4]; plain guard nullifies
    idle(); issue(1, 1'b1, 1'b1, 4); tick(1'b1);
    idle(); issue(0, 1'b0, 1'b1, 4); tick(1'b1);      // WAW on p4 stalls
    idle(); wb(4, 1'b0); tick(1'b1);
    idle(); issue(1, 1'b0, 1'b1, 4); tick(1'b1);      // nullified
    idle(); issue(0, 1'b0, 1'b1, 4); tick(1'b1);      // p4 idle: no stall
    idle(); wb(4, 1'b1); tick(1'b1);

    // Same-edge writeback and re-set of p5, then error on idle p6
    idle(); issue(0, 1'b0, 1'b1, 5); tick(1'b1);
    idle(); issue(0, 1'b0, 1'b1, 5); wb(5, 1'b1); tick(1'b1);
    idle(); rd_idx = 3'd5; issue(0, 1'b0, 1'b1, 5); tick(1'b1); // still busy
    idle(); wb(6, 1'b1); tick(1'b1);
    idle(); wb(5, 1'b0); tick(1'b1);
    check("wb_err_set", 16'(wb_err), 16'd1);

    // Flush with writeback to p2
    idle(); issue(0, 1'b0, 1'b1, 2); tick(1'b1);
    idle(); issue(0, 1'b0, 1'b1, 3); tick(1'b1);
    idle(); flush = 1'b1; wb(2, 1'b1); tick(1'b1);
    idle(); rd_idx = 3'd2; issue(2, 1'b0, 1'b1, 3); tick(1'b1);
    idle(); wb(3, 1'b0); tick(1'b1);

    // Reset overrides concurrent traffic
    idle(); rst_n = 1'b0; issue(0, 1'b0, 1'b1, 6); wb(7, 1'b1); flush = 1'b1; tick(1'b1);
    idle(); rd_idx = 3'd7; tick(1'b1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rst_n           = ($urandom_range(0, 99) != 0);
      issue_valid     = $urandom_range(0, 3) != 0;
      issue_guard_idx = 3'($urandom_range(0, 7));
      issue_guard_neg = 1'($urandom_range(0, 1));
      issue_dst_valid = 1'($urandom_range(0, 1));
      issue_dst_idx   = 3'($urandom_range(0, 7));
      wb_valid        = $urandom_range(0, 2) == 0;
      wb_idx          = 3'($urandom_range(0, 7));
      wb_data         = 1'($urandom_range(0, 1));
      flush           = $urandom_range(0, 31) == 0;
      rd_idx          = 3'($urandom_range(0, 7));
      tick(1'b1);
    end

    // Long stall to saturate the counter, then reset clears it
    idle(); tick(1'b1);
    idle(); issue(0, 1'b0, 1'b1, 1); tick(1'b1);
    idle(); issue(1, 1'b0, 1'b0, 0);
    for (int n = 0; n < 70000; n++) tick((n % 4096) == 0);
    tick(1'b1);
    check("stall_cnt_sat", stall_cnt, 16'hFFFF);
    rst_n = 1'b0; tick(1'b1);
    idle(); tick(1'b1);
    check("stall_cnt_rst", stall_cnt, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pred_regfile.md
PRED_REGFILE -- requirements
Module: pred_regfile

Interface
REQ-001 SHALL have parameter NUM_PRED, default 8: number of 1-bit predicate registers p0..p7.
REQ-002 SHALL have parameter PIDX_W, default 3: predicate index width.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 Port clk, input, 1: sole clock, rising edge.
REQ-005 Port rst_n, input, 1: synchronous active-low reset.
REQ-006 Port issue_valid, input, 1: decode presents an instruction this cycle.
REQ-007 Port issue_guard_idx, input, PIDX_W: guard predicate index.
REQ-008 Port issue_guard_neg, input, 1: invert guard.
REQ-009 Port issue_dst_valid, input, 1: the instruction writes a predicate.
REQ-010 Port issue_dst_idx, input, PIDX_W: destination predicate index.
REQ-011 Port issue_stall, output, 1: the instruction must be held this cycle.
REQ-012 Port issue_exec, output, 1: the instruction is accepted and its guard is true.
REQ-013 Port wb_valid, input, 1: predicate ALU result writeback from exec.
REQ-014 Port wb_idx, input, PIDX_W: writeback destination.
REQ-015 Port wb_data, input, 1: predicate ALU result bit.
REQ-016 Port flush, input, 1: pipeline squash.
REQ-017 Port rd_idx, input, PIDX_W: debug read index.
REQ-018 Port rd_data, output, 1: debug read value, combinational, no bypass.
REQ-019 Port wb_err, output, 1: sticky flag, writeback to a non-busy register.
REQ-020 Port stall_cnt, output, 16: saturating count of stalled issue cycles.

Function
REQ-021 p0 SHALL always read 1, SHALL never be busy, and SHALL ignore writes.
REQ-022 Guard value SHALL be wb_data when wb_valid and wb_idx==issue_guard_idx!=0; otherwise it SHALL be the stored value.
REQ-023 Guard is busy when busy[guard] is set and the REQ-022 bypass is not active.
REQ-024 Destination is busy when issue_dst_valid, dst!=0, busy[dst] is set, and the same-cycle writeback does not target dst.
REQ-025 issue_stall = issue_valid AND (guard busy OR destination busy), combinational.
REQ-026 issue_exec = issue_valid AND NOT issue_stall AND (guard value XOR issue_guard_neg), combinational.
REQ-027 On a clock edge with issue_exec, issue_dst_valid and dst!=0, busy[dst] SHALL be set.
REQ-028 Nullified instructions (accepted, guard false) SHALL NOT set busy.
REQ-029 On a clock edge with wb_valid and wb_idx!=0, the register SHALL take wb_data and busy[wb_idx] SHALL clear.
REQ-030 If a writeback and a busy set target the same index on the same edge, busy SHALL end set and the value SHALL be updated.
REQ-031 When a writeback targets a non-busy register, wb_err SHALL be set and the write SHALL still occur.
REQ-032 flush SHALL clear all busy bits on the edge, overriding REQ-027.
REQ-033 Under flush, a writeback in the same cycle SHALL still update the register value.
REQ-034 stall_cnt SHALL increment on each edge with issue_stall=1 and SHALL saturate at 16'hFFFF.
REQ-035 Scoreboard depth SHALL be one outstanding write per predicate; a WAW hazard stalls.

Reset
REQ-036 While rst_n=0 at an edge, all registers SHALL be set to 0 (p0 reads 1), busy to 0, wb_err to 0 and stall_cnt to 0.
REQ-037 Reset SHALL override issue, writeback and flush in the same cycle; combinational outputs SHALL reflect the reset state on the cycle after.

Structure
REQ-038 Package pred_pkg SHALL hold NUM_PRED, PIDX_W, the P_TRUE index (0) and the stall_cnt width.
REQ-039 Busy-bit tracking SHALL be one sub-module, pred_scoreboard (set/clear/flush, hazard outputs); the value array and counter SHALL stay in pred_regfile.

Verification
REQ-040 Reset, then issue guard=p0, neg=0 -> issue_exec=1, issue_stall=0; rd_idx=3 -> rd_data=0.
REQ-041 Issue dst=p2 (guard true), then next cycle issue guard=p2 -> issue_stall=1 and stall_cnt=1; then wb_valid, wb_idx=2, wb_data=1 -> same-cycle bypass gives issue_exec=1.
REQ-042 Guard=p1 holding 0 with neg=1, dst=p4 -> issue_exec=1 and busy[4] set; with neg=0 -> issue_exec=0 and busy[4] stays 0.
REQ-043 busy[5] set, with writeback idx 5 and a new issue dst=5 on the same edge -> busy[5]=1 and p5=wb_data; a later wb_idx=6 while non-busy -> wb_err=1.
REQ-044 busy[2] and busy[3] set, flush with wb_idx=2, wb_data=1 -> all busy bits 0, p2=1, wb_err unchanged.
REQ-045 Hold a stall for 70000 cycles -> stall_cnt=16'hFFFF; then rst_n=0 for one cycle -> stall_cnt=0.
